intack_ctrl: RTL

- Sequences the CPU interrupt-acknowledge handshake against the chipset interrupt controller.
- Qualifies the controller's interrupt request with the CPU interrupt flag and presents a request to the CPU.
- On CPU acceptance, issues the two single-cycle acknowledge pulses the controller requires, then captures the returned vector byte and hands it to the CPU.
- Sits between the CPU core's interrupt port and the interrupt controller, alongside the chipset I/O read-data mux.

---
 rtl/intack_ctrl_if.sv | 45 ++++
 rtl/intack_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/intack_ctrl_if.sv
// Interrupt-acknowledge handshake bundle: CPU interrupt port on one side,
// interrupt controller request/ack/read-data on the other.
interface intack_ctrl_if;
    logic       iInt;
    logic       iIF;
    logic       iCpuAck;
    logic       oIntReq;
    logic       oIntAck;
    logic       iPicSel;
    logic [7:0] iPicData;
    logic       oVecValid;
    logic [7:0] oVector;
    logic       oSpurious;
    logic       oBusy;

    // Sequencer side
    modport slave (
        input  iInt,
        input  iIF,
        input  iCpuAck,
        input  iPicSel,
        input  iPicData,
        output oIntReq,
        output oIntAck,
        output oVecValid,
        output oVector,
        output oSpurious,
        output oBusy
    );

    // Environment side (CPU core + interrupt controller)
    modport master (
        output iInt,
        output iIF,
        output iCpuAck,
        output iPicSel,
        output iPicData,
        input  oIntReq,
        input  oIntAck,
        input  oVecValid,
        input  oVector,
        input  oSpurious,
        input  oBusy
    );
endinterface

// File: rtl/intack_ctrl.sv
// Interrupt-acknowledge sequencer. Qualifies the controller request with the
// CPU interrupt flag, issues the two-pulse acknowledge the controller needs,
// then captures the returned vector (or substitutes a spurious vector on
// timeout) and hands it to the CPU. All outputs are registered.
module intack_ctrl #(
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned HOLDOFF      = 2,
    parameter logic [7:0]  SPURIOUS_VEC = 8'h0F
) (
    input  logic         iClk,
    input  logic         iRst,
    intack_ctrl_if.slave bus
);

    localparam logic [7:0] LP_GAP     = 8'(GAP_CYCLES);
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);
    localparam logic [7:0] LP_HOLDOFF = 8'(HOLDOFF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK1,
        ST_GAP,
        ST_ACK2,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_int_req;
    logic       r_int_ack;
    logic       r_vec_valid;
    logic [7:0] r_vector;
    logic       r_spurious;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_int_req_nxt;
    logic       w_int_ack_nxt;
    logic       w_vec_valid_nxt;
    logic [7:0] w_vector_nxt;
    logic       w_spurious_nxt;
    logic       w_busy_nxt;

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_int_req_nxt   = r_int_req;
        w_int_ack_nxt   = 1'b0;
        w_vec_valid_nxt = 1'b0;
        w_vector_nxt    = r_vector;
        w_spurious_nxt  = r_spurious;

        case (r_state)
            ST_IDLE: begin
                w_int_req_nxt = 1'b0;
                if (bus.iInt && bus.iIF) begin
                    w_state_nxt   = ST_REQ;
                    w_int_req_nxt = 1'b1;
                end
            end

            ST_REQ: begin
                w_int_req_nxt = 1'b1;
                // CPU acceptance takes priority over a simultaneous withdrawal:
                // once the CPU has committed, both pulses must follow.
                if (bus.iCpuAck) begin
                    w_state_nxt   = ST_ACK1;
                    w_int_req_nxt = 1'b0;
                    w_int_ack_nxt = 1'b1;
                end else if (!bus.iInt || !bus.iIF) begin
                    w_state_nxt   = ST_IDLE;
                    w_int_req_nxt = 1'b0;
                end
            end

            ST_ACK1: begin
                w_cnt_nxt   = LP_GAP;
                w_state_nxt = ST_GAP;
            end

            // Count values <= 1 terminate so a zero count cannot wrap to 255
            ST_GAP: begin
                if (r_cnt <= 8'd1) begin
                    w_cnt_nxt     = 8'd0;
                    w_int_ack_nxt = 1'b1;
                    w_state_nxt   = ST_ACK2;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            ST_ACK2: begin
                w_cnt_nxt   = LP_TIMEOUT;
                w_state_nxt = ST_WAIT;
            end

            // Only here is controller read data treated as a vector
            ST_WAIT: begin
                if (bus.iPicSel) begin
                    w_vector_nxt    = bus.iPicData;
                    w_vec_valid_nxt = 1'b1;
                    w_cnt_nxt       = LP_HOLDOFF;
                    w_state_nxt     = ST_HOLD;
                end else if (r_cnt <= 8'd1) begin
                    w_vector_nxt    = SPURIOUS_VEC;
                    w_vec_valid_nxt = 1'b1;
                    w_spurious_nxt  = 1'b1;
                    w_cnt_nxt       = LP_HOLDOFF;
                    w_state_nxt     = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            // Masks the controller's registered request while its ISR update
            // propagates, so the serviced request is not taken a second time.
            ST_HOLD: begin
                if (r_cnt <= 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = 8'd0;
                w_int_req_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset is evaluated last so it overrides all
    always_ff @(posedge iClk) begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_int_req   <= w_int_req_nxt;
        r_int_ack   <= w_int_ack_nxt;
        r_vec_valid <= w_vec_valid_nxt;
        r_vector    <= w_vector_nxt;
        r_spurious  <= w_spurious_nxt;
        r_busy      <= w_busy_nxt;
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_int_req   <= 1'b0;
            r_int_ack   <= 1'b0;
            r_vec_valid <= 1'b0;
            r_vector    <= 8'd0;
            r_spurious  <= 1'b0;
            r_busy      <= 1'b0;
        end
    end

    assign bus.oIntReq   = r_int_req;
    assign bus.oIntAck   = r_int_ack;
    assign bus.oVecValid = r_vec_valid;
    assign bus.oVector   = r_vector;
    assign bus.oSpurious = r_spurious;
    assign bus.oBusy     = r_busy;

endmodule
